// File: rtl/f8_supervisor_pkg.sv
// Shared types for the f8 reset/trap supervisor.
package f8_supervisor_pkg;

    typedef enum logic [1:0] {
        RESET_HOLD = 2'd0,
        RUN        = 2'd1,
        HALT       = 2'd2
    } sup_state_e;

    localparam int MODE_HALT    = 0;
    localparam int MODE_RESTART = 1;

endpackage

// File: rtl/system_supervisor_if.sv
// Trap/watchdog inputs and status outputs between the supervisor and the system top.
interface system_supervisor_if #(
    parameter int NTRAP    = 2,
    parameter int WDT_BITS = 16
);
    logic [NTRAP-1:0]    trap;
    logic                wdt_enable;
    logic                wdt_kick;
    logic [WDT_BITS-1:0] wdt_timeout;
    logic                core_reset;
    logic                ready;
    logic                halted;
    logic [NTRAP-1:0]    trap_cause;
    logic                wdt_expired;
    logic [7:0]          restart_count;

    modport master (
        output trap, wdt_enable, wdt_kick, wdt_timeout,
        input  core_reset, ready, halted, trap_cause, wdt_expired, restart_count
    );

    modport slave (
        input  trap, wdt_enable, wdt_kick, wdt_timeout,
        output core_reset, ready, halted, trap_cause, wdt_expired, restart_count
    );
endinterface

// File: rtl/supervisor_wdt.sv
// Watchdog down-counter; expire is a combinational pulse flagging the edge the count runs out.
module supervisor_wdt #(
    parameter int WDT_BITS = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                run,
    input  logic                enable,
    input  logic                kick,
    input  logic [WDT_BITS-1:0] timeout,
    output logic                expire
);
    logic [WDT_BITS-1:0] cnt;
    logic                active;

    assign active = run && enable && (timeout != '0);
    // The edge that would take the count to zero is the expiry edge; a kick on it wins.
    assign expire = active && !kick && ((cnt >> 1) == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= timeout;
        end else if (active) begin
            if (kick)
                cnt <= timeout;
            else if (cnt != '0)
                cnt <= cnt - 1'b1;
        end
    end
endmodule

// File: rtl/system_supervisor.sv
// Reset sequencer and trap/watchdog supervisor: holds the core in reset, then halts or
// restarts it on faults depending on TRAP_MODE.
module system_supervisor
    import f8_supervisor_pkg::*;
#(
    parameter int RESET_CYCLES = 8,
    parameter int NTRAP        = 2,
    parameter int WDT_BITS     = 16,
    parameter int TRAP_MODE    = 0,
    parameter int MAX_RETRIES  = 3
) (
    input  logic                clk,
    input  logic                power_on_reset_n,
    system_supervisor_if.slave  sup
);
    localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [7:0] RETRY_LIMIT = 8'(MAX_RETRIES);

    sup_state_e        state, next_state;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic [NTRAP-1:0]  cause_q, cause_nxt;
    logic              wexp_q, wexp_nxt;
    logic [7:0]        rc_q, rc_nxt;
    logic              core_reset_q, ready_q, halted_q;
    logic              wdt_load, wdt_fire, fault;

    supervisor_wdt #(.WDT_BITS(WDT_BITS)) u_wdt (
        .clk     (clk),
        .rst_n   (power_on_reset_n),
        .load    (wdt_load),
        .run     (state == RUN),
        .enable  (sup.wdt_enable),
        .kick    (sup.wdt_kick),
        .timeout (sup.wdt_timeout),
        .expire  (wdt_fire)
    );

    assign fault = (state == RUN) && ((|sup.trap) || wdt_fire);

    always_comb begin
        next_state = state;
        hold_nxt   = hold_cnt;
        cause_nxt  = cause_q;
        wexp_nxt   = wexp_q;
        rc_nxt     = rc_q;
        wdt_load   = 1'b0;
        case (state)
            RESET_HOLD: begin
                if (hold_cnt == '0) begin
                    next_state = RUN;
                    wdt_load   = 1'b1;
                end else begin
                    hold_nxt = hold_cnt - 1'b1;
                end
            end
            RUN: begin
                if (fault) begin
                    // A trap and an expiry on the same edge are both recorded as one fault.
                    cause_nxt = cause_q | sup.trap;
                    wexp_nxt  = wexp_q | wdt_fire;
                    if (TRAP_MODE == MODE_HALT || rc_q == RETRY_LIMIT) begin
                        next_state = HALT;
                    end else begin
                        rc_nxt     = rc_q + 8'd1;
                        next_state = RESET_HOLD;
                        hold_nxt   = HOLD_INIT;
                    end
                end
            end
            HALT: ;
            default: begin
                next_state = RESET_HOLD;
                hold_nxt   = HOLD_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!power_on_reset_n) begin
            state        <= RESET_HOLD;
            hold_cnt     <= HOLD_INIT;
            cause_q      <= '0;
            wexp_q       <= 1'b0;
            rc_q         <= '0;
            core_reset_q <= 1'b1;
            ready_q      <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state        <= next_state;
            hold_cnt     <= hold_nxt;
            cause_q      <= cause_nxt;
            wexp_q       <= wexp_nxt;
            rc_q         <= rc_nxt;
            core_reset_q <= (next_state != RUN);
            ready_q      <= (next_state == RUN);
            halted_q     <= (next_state == HALT);
        end
    end

    assign sup.core_reset    = core_reset_q;
    assign sup.ready         = ready_q;
    assign sup.halted        = halted_q;
    assign sup.trap_cause    = cause_q;
    assign sup.wdt_expired   = wexp_q;
    assign sup.restart_count = rc_q;
endmodule

// File: doc/system_supervisor.md
Name: system_supervisor

Overview:
Synthesisable reset/trap supervisor for the f8 system, replacing bench-only reset pulse and trap-stop logic. Sequences core reset after power-on, watches NTRAP trap sources plus an optional watchdog, and per mode either halts the core or restarts it up to a retry limit. Sits between the board reset/clock and the system top; drives the core's reset and exposes sticky fault status.

Parameters:
RESET_CYCLES, 8, cycles core_reset is held after each reset entry (>=1)
NTRAP, 2, number of trap input channels (>=1)
WDT_BITS, 16, width of the watchdog counter
TRAP_MODE, 0, 0 = halt on fault, 1 = restart on fault until retries exhausted
MAX_RETRIES, 3, restarts allowed in mode 1 (1..255)

Ports:
clk  input  1  system clock
power_on_reset_n  input  1  synchronous, active-low reset
trap  input  NTRAP  per-channel trap request, sampled each clk edge
wdt_enable  input  1  watchdog enable
wdt_kick  input  1  reload watchdog
wdt_timeout  input  WDT_BITS  watchdog reload value; 0 = watchdog disabled
core_reset  output  1  active-high reset to the core/system
ready  output  1  high while in RUN
halted  output  1  sticky; core parked in reset
trap_cause  output  NTRAP  sticky OR of trap channels seen in RUN
wdt_expired  output  1  sticky watchdog-expiry flag
restart_count  output  8  restarts performed, saturates at MAX_RETRIES

Behaviour:
- One clock; reset is synchronous and active-low. All outputs registered.
- power_on_reset_n low at an edge: state RESET_HOLD, hold counter = RESET_CYCLES-1, core_reset=1, ready=0, halted=0, trap_cause=0, wdt_expired=0, restart_count=0, watchdog counter cleared. Overrides any state, including mid-restart or HALT.
- States: RESET_HOLD, RUN, HALT.
- RESET_HOLD: core_reset=1; counter decrements each edge; edge where counter==0 -> RUN. core_reset falls exactly RESET_CYCLES edges after first edge with power_on_reset_n high. trap and watchdog ignored.
- RUN entry: watchdog loads wdt_timeout; ready=1, core_reset=0.
- RUN, watchdog active when wdt_enable=1 and wdt_timeout!=0: decrement per edge; wdt_kick reloads wdt_timeout; at 0 with no kick -> fault, wdt_expired=1. Kick and expiry same edge: kick wins, no fault. wdt_enable low: counter holds, no expiry.
- RUN, trap!=0 at an edge -> fault; trap_cause |= trap. Trap and expiry same edge: both recorded, one fault.
- Fault (1-cycle latency: core_reset=1 and ready=0 from fault edge):
  - TRAP_MODE==0, or restart_count==MAX_RETRIES -> HALT.
  - else restart_count+1, RESET_HOLD with counter reloaded.
- HALT: core_reset=1, halted=1, ready=0; only exit is power_on_reset_n low.
- trap_cause, wdt_expired, restart_count survive restarts; cleared only by power_on_reset_n.
- Trap inputs asserted in RESET_HOLD or HALT never alter trap_cause.

Decomposition:
- Package f8_supervisor_pkg: state enum (RESET_HOLD, RUN, HALT), TRAP_MODE constants (MODE_HALT=0, MODE_RESTART=1).
- Sub-module supervisor_wdt: WDT_BITS down-counter with load/kick/enable and one-cycle expire pulse; main FSM in system_supervisor.

Test Plan:
- Power-on: reset_n low 3 cycles then high, RESET_CYCLES=8 -> core_reset falls on 8th edge after release, ready=1 same edge, all status 0.
- Mode 0 trap: in RUN pulse trap=2'b10 one cycle -> core_reset=1 next edge, halted=1, trap_cause=2'b10, restart_count=0; later traps no effect; reset_n low clears all.
- Mode 1 retries, MAX_RETRIES=3: trap after each RUN entry -> restart_count 1,2,3 with 8-cycle holds; 4th trap -> HALT, restart_count=3.
- Watchdog: enable, timeout=5, no kick -> fault on 5th edge after RUN entry, wdt_expired=1; with kick every 4 cycles -> no fault over 100 cycles; kick on expiry edge -> no fault.
- Simultaneous: trap=2'b01 on watchdog-expiry edge -> one fault, trap_cause=2'b01, wdt_expired=1, restart_count +1 only.
- Mid-sequence reset: reset_n low during RESET_HOLD of a restart and during HALT -> full reinit, restart_count=0, fresh 8-cycle hold.
